// File: rtl/mac_rx_interface.sv
// Receive-side store-and-forward frame FIFO between the MAC Rx AXI-Stream port and the NIC pipe.
// Frames are written speculatively and only become visible to the reader once their good tlast beat lands.
module mac_rx_interface #(
    parameter int MAC_WIDTH   = 64,
    parameter int TKEEP_WIDTH = MAC_WIDTH / 8,
    parameter int NIC_WIDTH   = MAC_WIDTH + TKEEP_WIDTH + 1,
    parameter int ADDR_WIDTH  = 9
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [MAC_WIDTH-1:0]   rx_axis_tdata,
    input  logic [TKEEP_WIDTH-1:0] rx_axis_tkeep,
    input  logic                   rx_axis_tvalid,
    input  logic                   rx_axis_tlast,
    input  logic                   rx_axis_tuser,
    output logic [NIC_WIDTH-1:0]   RX_FIFO_pipe_read_data,
    input  logic                   RX_FIFO_pipe_read_req,
    output logic                   RX_FIFO_pipe_read_ack,
    output logic [31:0]            rx_good_frames,
    output logic [31:0]            rx_dropped_frames
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    localparam logic [ADDR_WIDTH:0] PTR_ONE    = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RECV = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    logic [NIC_WIDTH-1:0]  mem [DEPTH];

    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   commit_ptr_q, commit_ptr_d;
    logic [1:0]            state_q, state_d;
    logic [31:0]           good_cnt_q, good_cnt_d;
    logic [31:0]           drop_cnt_q, drop_cnt_d;

    logic [ADDR_WIDTH:0]   used_words;
    logic                  fifo_full;
    logic                  wr_en;
    logic                  rd_en;
    logic [NIC_WIDTH-1:0]  wr_word;

    // Full uses the pre-edge rd_ptr, so a slot freed by a read this cycle is reusable next cycle.
    assign used_words = wr_ptr_q - rd_ptr_q;
    assign fifo_full  = (used_words == FULL_COUNT);
    assign wr_word    = {rx_axis_tlast, rx_axis_tdata, rx_axis_tkeep};

    // The reader only ever sees words below commit_ptr; speculative beats stay hidden.
    assign RX_FIFO_pipe_read_ack  = (rd_ptr_q != commit_ptr_q);
    assign RX_FIFO_pipe_read_data = mem[rd_ptr_q[ADDR_WIDTH-1:0]];
    assign rd_en                  = RX_FIFO_pipe_read_req && RX_FIFO_pipe_read_ack;

    assign rx_good_frames    = good_cnt_q;
    assign rx_dropped_frames = drop_cnt_q;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        good_cnt_d   = good_cnt_q;
        drop_cnt_d   = drop_cnt_q;
        wr_en        = 1'b0;
        rd_ptr_d     = rd_en ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

        if (rx_axis_tvalid) begin
            case (state_q)
                ST_IDLE, ST_RECV: begin
                    if (!fifo_full) begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + PTR_ONE;
                        if (!rx_axis_tlast) begin
                            state_d = ST_RECV;
                        end else if (rx_axis_tuser) begin
                            commit_ptr_d = wr_ptr_q + PTR_ONE;
                            good_cnt_d   = good_cnt_q + 32'd1;
                            state_d      = ST_IDLE;
                        end else begin
                            wr_ptr_d   = commit_ptr_q;
                            drop_cnt_d = drop_cnt_q + 32'd1;
                            state_d    = ST_IDLE;
                        end
                    end else begin
                        // Overflow: abandon the partial frame now and swallow the rest of it.
                        wr_ptr_d = commit_ptr_q;
                        if (rx_axis_tlast) begin
                            drop_cnt_d = drop_cnt_q + 32'd1;
                            state_d    = ST_IDLE;
                        end else begin
                            state_d = ST_DROP;
                        end
                    end
                end
                ST_DROP: begin
                    if (rx_axis_tlast) begin
                        drop_cnt_d = drop_cnt_q + 32'd1;
                        state_d    = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            state_q      <= ST_IDLE;
            good_cnt_q   <= '0;
            drop_cnt_q   <= '0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            state_q      <= state_d;
            good_cnt_q   <= good_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    // NOTE: the storage array has no reset; pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= wr_word;
        end
    end

endmodule

// File: tb/tb_mac_rx_interface.sv
// Directed bench for mac_rx_interface: a queue-based frame model is compared every cycle,
// and each scenario also pins hand-computed word counts, contents and counter values.
module tb_mac_rx_interface;

    logic         clk;
    logic         reset;
    logic [63:0]  rx_axis_tdata;
    logic [7:0]   rx_axis_tkeep;
    logic         rx_axis_tvalid;
    logic         rx_axis_tlast;
    logic         rx_axis_tuser;
    logic [72:0]  rd_data;
    logic         rd_req;
    logic         rd_ack;
    logic [31:0]  good_frames;
    logic [31:0]  dropped_frames;

    int tests_run = 0;
    int tests_failed = 0;

    mac_rx_interface dut (
        .clk                    (clk),
        .reset                  (reset),
        .rx_axis_tdata          (rx_axis_tdata),
        .rx_axis_tkeep          (rx_axis_tkeep),
        .rx_axis_tvalid         (rx_axis_tvalid),
        .rx_axis_tlast          (rx_axis_tlast),
        .rx_axis_tuser          (rx_axis_tuser),
        .RX_FIFO_pipe_read_data (rd_data),
        .RX_FIFO_pipe_read_req  (rd_req),
        .RX_FIFO_pipe_read_ack  (rd_ack),
        .rx_good_frames         (good_frames),
        .rx_dropped_frames      (dropped_frames)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Frame-level model: committed words readable by the NIC, plus the frame still being received.
    logic [72:0]  m_committed[$];
    logic [72:0]  m_pending[$];
    bit           m_discarding;
    int unsigned  m_good;
    int unsigned  m_dropped;

    always @(posedge clk) begin
        if (reset) begin
            m_committed.delete();
            m_pending.delete();
            m_discarding = 1'b0;
            m_good       = 0;
            m_dropped    = 0;
        end else begin
            int  occupancy;
            bit  reading;
            occupancy = m_committed.size() + m_pending.size();
            reading   = rd_req && (m_committed.size() != 0);
            if (reading) void'(m_committed.pop_front());
            if (rx_axis_tvalid) begin
                if (m_discarding) begin
                    if (rx_axis_tlast) begin
                        m_dropped++;
                        m_discarding = 1'b0;
                    end
                end else if (occupancy == 512) begin
                    m_pending.delete();
                    if (rx_axis_tlast) m_dropped++;
                    else m_discarding = 1'b1;
                end else begin
                    m_pending.push_back({rx_axis_tlast, rx_axis_tdata, rx_axis_tkeep});
                    if (rx_axis_tlast) begin
                        if (rx_axis_tuser) begin
                            foreach (m_pending[i]) m_committed.push_back(m_pending[i]);
                            m_good++;
                        end else begin
                            m_dropped++;
                        end
                        m_pending.delete();
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("ack_vs_model", rd_ack, m_committed.size() != 0);
            if (m_committed.size() != 0) check("data_vs_model", rd_data, m_committed[0]);
            check("good_vs_model", good_frames, m_good);
            check("dropped_vs_model", dropped_frames, m_dropped);
        end
    end

    // Words the NIC side actually transferred.
    logic [72:0] got[$];
    always @(negedge clk) begin
        if (!reset && rd_req && rd_ack) got.push_back(rd_data);
    end

    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic last, input logic user);
        @(posedge clk); #1;
        rx_axis_tvalid = 1'b1;
        rx_axis_tdata  = d;
        rx_axis_tkeep  = k;
        rx_axis_tlast  = last;
        rx_axis_tuser  = user;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            rx_axis_tvalid = 1'b0;
            rx_axis_tlast  = 1'b0;
            rx_axis_tuser  = 1'b0;
        end
    endtask

    // tuser is driven high only on the tlast beat so mid-frame tuser=0 must be ignored.
    task automatic send_seq_frame(input int base, input int len, input logic user);
        for (int i = 0; i < len; i++)
            send_beat(64'(base + i), 8'hFF, i == len - 1, (i == len - 1) ? user : 1'b0);
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        reset = 1'b1; rd_req = 1'b0;
        rx_axis_tvalid = 1'b0; rx_axis_tlast = 1'b0; rx_axis_tuser = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic drain(input string name, input int max_cycles);
        rd_req = 1'b1;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (!rd_ack) break;
        end
        check(name, rd_ack, 1'b0);
        @(posedge clk); #1;
        rd_req = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int errs;
        reset = 1'b1; rd_req = 1'b0;
        rx_axis_tvalid = 1'b0; rx_axis_tdata = '0; rx_axis_tkeep = '0;
        rx_axis_tlast = 1'b0; rx_axis_tuser = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        check("reset_ack", rd_ack, 1'b0);
        check("reset_good", good_frames, 32'd0);
        check("reset_dropped", dropped_frames, 32'd0);

        // Good 3-beat frame, tlast-to-ack latency and in-order read.
        send_beat(64'h1111_1111_1111_1111, 8'hFF, 1'b0, 1'b0);
        send_beat(64'h2222_2222_2222_2222, 8'hFF, 1'b0, 1'b0);
        send_beat(64'h3333_3333_3333_3333, 8'h0F, 1'b1, 1'b1);
        check("good_ack_before_tlast_edge", rd_ack, 1'b0);
        idle(1);
        check("good_ack_after_tlast_edge", rd_ack, 1'b1);
        check("good_count", good_frames, 32'd1);
        got.delete();
        drain("good_drain", 20);
        check("good_words", got.size(), 3);
        check("good_w0", got[0], {1'b0, 64'h1111_1111_1111_1111, 8'hFF});
        check("good_w1", got[1], {1'b0, 64'h2222_2222_2222_2222, 8'hFF});
        check("good_w2", got[2], {1'b1, 64'h3333_3333_3333_3333, 8'h0F});

        // Bad frame immediately followed by a good one.
        apply_reset();
        send_seq_frame(32'hA0, 4, 1'b0);
        send_seq_frame(32'hB0, 2, 1'b1);
        idle(1);
        got.delete();
        drain("bad_drain", 20);
        check("bad_words", got.size(), 2);
        check("bad_w0", got[0], {1'b0, 64'hB0, 8'hFF});
        check("bad_w1", got[1], {1'b1, 64'hB1, 8'hFF});
        check("bad_dropped", dropped_frames, 32'd1);
        check("bad_good", good_frames, 32'd1);

        // Overflow: 500 stored, 20-beat frame overruns after 12 beats and is discarded.
        apply_reset();
        send_seq_frame(0, 500, 1'b1);
        send_seq_frame(1000, 20, 1'b1);
        idle(1);
        check("ovf_model_words", m_committed.size(), 500);
        check("ovf_dropped", dropped_frames, 32'd1);
        check("ovf_good", good_frames, 32'd1);
        got.delete();
        drain("ovf_drain", 600);
        check("ovf_words", got.size(), 500);
        check("ovf_first", got[0], {1'b0, 64'd0, 8'hFF});
        check("ovf_last", got[499], {1'b1, 64'd499, 8'hFF});
        send_seq_frame(2000, 5, 1'b1);
        idle(1);
        got.delete();
        drain("ovf_next_drain", 20);
        check("ovf_next_words", got.size(), 5);
        check("ovf_next_w0", got[0], {1'b0, 64'd2000, 8'hFF});
        check("ovf_next_w4", got[4], {1'b1, 64'd2004, 8'hFF});
        check("ovf_next_good", good_frames, 32'd2);

        // Concurrent read and write, back-to-back 1-beat and 2-beat frames.
        apply_reset();
        got.delete();
        rd_req = 1'b1;
        send_seq_frame(3000, 1, 1'b1);
        send_seq_frame(3001, 2, 1'b1);
        idle(1);
        drain("conc_drain", 20);
        check("conc_words", got.size(), 3);
        check("conc_w0", got[0], {1'b1, 64'd3000, 8'hFF});
        check("conc_w1", got[1], {1'b0, 64'd3001, 8'hFF});
        check("conc_w2", got[2], {1'b1, 64'd3002, 8'hFF});

        // Pointer wrap: 40 frames x 30 beats read while being written.
        apply_reset();
        got.delete();
        rd_req = 1'b1;
        for (int f = 0; f < 40; f++) send_seq_frame(f * 30, 30, 1'b1);
        idle(1);
        drain("wrap_drain", 200);
        check("wrap_words", got.size(), 1200);
        errs = 0;
        foreach (got[i]) begin
            if (got[i] !== {(i % 30) == 29, 64'(i), 8'hFF}) errs++;
        end
        check("wrap_sequence_errors", errs, 0);
        check("wrap_good", good_frames, 32'd40);

        // Reset with two committed frames buffered.
        apply_reset();
        send_seq_frame(4000, 3, 1'b1);
        send_seq_frame(4100, 3, 1'b1);
        idle(1);
        check("rst_ack_buffered", rd_ack, 1'b1);
        apply_reset();
        check("rst_ack", rd_ack, 1'b0);
        check("rst_good", good_frames, 32'd0);
        check("rst_dropped", dropped_frames, 32'd0);
        send_seq_frame(5000, 4, 1'b1);
        idle(1);
        got.delete();
        drain("rst_drain", 20);
        check("rst_words", got.size(), 4);
        check("rst_w0", got[0], {1'b0, 64'd5000, 8'hFF});
        check("rst_w3", got[3], {1'b1, 64'd5003, 8'hFF});
        check("rst_good_after", good_frames, 32'd1);

        idle(2);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mac_rx_interface.md
# mac_rx_interface

Receive-side counterpart of the MAC Tx interface. Accepts frame beats from the Ethernet MAC receive AXI-Stream port, which has no backpressure, and stores them in a store-and-forward frame FIFO. Only complete, good frames are committed. The NIC reads committed frames through the RX FIFO pipe as `{tlast, tdata, tkeep}` words, which is the same word format the Tx interface consumes.

## Interface
- `MAC_WIDTH`, 64, data beat width.
- `TKEEP_WIDTH`, 8, byte-enable width (`MAC_WIDTH/8`).
- `NIC_WIDTH`, `MAC_WIDTH+TKEEP_WIDTH+1`, pipe word width.
- `ADDR_WIDTH`, 9, FIFO depth is `2**ADDR_WIDTH` words (512).

Ports:
- `clk`  in  1  single clock for all logic.
- `reset`  in  1  synchronous, active-high.
- `rx_axis_tdata`  in  `MAC_WIDTH`  beat data.
- `rx_axis_tkeep`  in  `TKEEP_WIDTH`  byte enables.
- `rx_axis_tvalid`  in  1  beat valid; the MAC never waits.
- `rx_axis_tlast`  in  1  last beat of frame.
- `rx_axis_tuser`  in  1  sampled only on the tlast beat: 1 = good frame, 0 = bad (FCS or length error).
- `RX_FIFO_pipe_read_data`  out  `NIC_WIDTH`  `{tlast, tdata, tkeep}` at the head.
- `RX_FIFO_pipe_read_req`  in  1  NIC requests a word.
- `RX_FIFO_pipe_read_ack`  out  1  a committed word is available.
- `rx_good_frames`  out  32  count of committed frames, wraps.
- `rx_dropped_frames`  out  32  count of dropped frames (bad or overflow), wraps.

## Operation
- **Pointers:** `rd_ptr`, `wr_ptr` (speculative) and `commit_ptr`, each `ADDR_WIDTH+1` bits with natural wrap.
  - Used words = `wr_ptr - rd_ptr`.
  - Full when used words equal `2**ADDR_WIDTH`.
  - All `2**ADDR_WIDTH` entries are usable.
- **Write FSM:** states IDLE, RECV, DROP.
- **IDLE or RECV, valid beat, FIFO not full:**
  - Write `{tlast, tdata, tkeep}` at `wr_ptr` and increment `wr_ptr`.
  - Without tlast: go to RECV.
  - With tlast and tuser=1: set `commit_ptr` to the new `wr_ptr`, increment `rx_good_frames`, go to IDLE.
  - With tlast and tuser=0: set `wr_ptr` back to `commit_ptr`, increment `rx_dropped_frames`, go to IDLE.
- **IDLE or RECV, valid beat, FIFO full (overflow):**
  - The beat is not written and `wr_ptr` is set back to `commit_ptr`.
  - If tlast: increment `rx_dropped_frames` and go to IDLE.
  - Otherwise go to DROP.
- **DROP:** discard all beats. On the tlast beat, increment `rx_dropped_frames` and go to IDLE.
- Frames longer than `2**ADDR_WIDTH` beats are always dropped.
- **Read side:**
  - `RX_FIFO_pipe_read_ack` = (`rd_ptr != commit_ptr`).
  - `RX_FIFO_pipe_read_data` = `mem[rd_ptr]`, read asynchronously (first-word fall-through).
  - A transfer happens when req and ack are both high at a clock edge; `rd_ptr` then increments.
  - Uncommitted words are never visible to the reader.
- **Concurrent access:** a read and a write in the same cycle are both performed. Full is evaluated with the pre-edge `rd_ptr`, so a slot freed this cycle is usable on the next cycle.
- **Reset:**
  - All pointers and both counters go to 0, state goes to IDLE.
  - `RX_FIFO_pipe_read_ack` is 0 and `RX_FIFO_pipe_read_data` is don't-care.
  - Memory contents are not cleared.
  - The MAC shares `reset`, so no partial frame is in flight at reset release.

## Timing
- Beat write latency: one edge.
- The tlast beat accepted at edge N makes ack high after edge N, so the first word can be read at edge N+1. Tlast-to-ack latency is 1 cycle.
- Sustained throughput is 1 word/cycle on both sides.
- With req held high, one word transfers per cycle until ack falls. After the frame's last word transfers, ack stays high if a further committed frame exists.
- Counter updates are visible the cycle after the tlast edge.
- A rollback (bad frame or overflow) takes effect at the same edge. The next frame's first beat may arrive on the very next cycle and is written at the restored `wr_ptr`.
- Back-to-back frames with no idle cycle between tlast and the next first beat must be supported.

## Test plan
- **Good frame:** 3 beats (0x11.., 0x22.., 0x33.., tkeep 0xFF, 0xFF, 0x0F, tuser=1).
  - Ack rises 1 cycle after the tlast beat.
  - With req held high, 3 words read in order, with tlast set only on word 3.
  - `rx_good_frames`=1.
- **Bad frame:** 4-beat frame with tuser=0, followed immediately by a 2-beat good frame.
  - Only the 2 good words are read.
  - `rx_dropped_frames`=1, `rx_good_frames`=1.
- **Overflow:** req held low; 500-beat good frame, then 20-beat frame.
  - Second frame is dropped via DROP.
  - Then read all; exactly 500 words, `rx_dropped_frames`=1.
  - A subsequent 5-beat frame is committed correctly.
- **Concurrent read/write:** a 1-beat frame and a 2-beat frame, back to back with no gap, while req is held high.
  - Continuous reads with no lost or duplicated words.
- **Pointer wrap:** 40 frames of 30 beats, read concurrently.
  - All 1200 words match their sequence number across the 512-word wrap.
- **Reset:** assert reset with 2 committed frames buffered.
  - Ack is 0 the cycle after reset, both counters are 0.
  - The next frame reads back correctly.
